// File: rtl/rans_byte_packer.sv
// Packs the rANS encoder's 0..2 renormalisation bytes per beat into little-endian
// 32-bit words with byte keep and packet-last, buffered in a small word FIFO.
module rans_byte_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  valid_i,
    input  logic [15:0] enc_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_keep_o,
    output logic        m_last_o,
    output logic        m_valid_o,
    input  logic        m_ready_i
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] READY_MAX = OW'(FIFO_DEPTH - 2);

    function automatic logic [3:0] keep_mask(input logic [2:0] n);
        case (n)
            3'd0:    keep_mask = 4'h0;
            3'd1:    keep_mask = 4'h1;
            3'd2:    keep_mask = 4'h3;
            3'd3:    keep_mask = 4'h7;
            default: keep_mask = 4'hF;
        endcase
    endfunction

    logic [23:0]   acc_q;
    logic [1:0]    acc_cnt_q;
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [3:0]    mem_keep [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_nxt1;
    logic [OW-1:0] occ_q;

    logic          accept;
    logic          pop;
    logic [15:0]   new_bytes;
    logic [2:0]    new_cnt;
    logic [2:0]    total;
    logic [23:0]   acc_clean;
    logic [39:0]   merged;
    logic          full_push;
    logic          flush_acc;
    logic [2:0]    rem_cnt;
    logic [23:0]   rem_data;
    logic          p0_v, p1_v;
    logic [31:0]   p0_data, p1_data;
    logic [3:0]    p0_keep, p1_keep;
    logic          p0_last, p1_last;
    logic [1:0]    push_cnt;

    // Two free entries guarantee room for the worst case: full word plus flush word.
    assign ready_o     = (occ_q <= READY_MAX);
    assign accept      = ready_o;
    assign m_valid_o   = (occ_q != '0);
    assign pop         = m_valid_o && m_ready_i;
    assign wr_ptr_nxt1 = wr_ptr_q + PW'(1);

    assign m_data_o = m_valid_o ? mem_data[rd_ptr_q] : 32'h0;
    assign m_keep_o = m_valid_o ? mem_keep[rd_ptr_q] : 4'h0;
    assign m_last_o = m_valid_o ? mem_last[rd_ptr_q] : 1'b0;

    always_comb begin
        new_bytes = 16'h0;
        new_cnt   = 3'd0;
        case (valid_i)
            2'b01: begin new_bytes = {8'h0, enc_i[7:0]};  new_cnt = 3'd1; end
            2'b10: begin new_bytes = {8'h0, enc_i[15:8]}; new_cnt = 3'd1; end
            2'b11: begin new_bytes = enc_i;               new_cnt = 3'd2; end
            default: ;
        endcase

        case (acc_cnt_q)
            2'd0:    acc_clean = 24'h0;
            2'd1:    acc_clean = {16'h0, acc_q[7:0]};
            2'd2:    acc_clean = {8'h0, acc_q[15:0]};
            default: acc_clean = acc_q;
        endcase

        // New bytes land directly after the pending ones, lane by lane.
        merged    = {16'h0, acc_clean} | ({24'h0, new_bytes} << {acc_cnt_q, 3'b000});
        total     = {1'b0, acc_cnt_q} + new_cnt;
        full_push = accept && (total >= 3'd4);
        flush_acc = accept && flush_i;

        if (full_push) begin
            rem_cnt  = total - 3'd4;
            rem_data = {16'h0, merged[39:32]};
        end else begin
            rem_cnt  = total;
            rem_data = merged[23:0];
        end

        p0_v    = 1'b0;
        p0_data = 32'h0;
        p0_keep = 4'h0;
        p0_last = 1'b0;
        p1_v    = 1'b0;
        p1_data = 32'h0;
        p1_keep = 4'h0;
        p1_last = 1'b0;
        if (full_push) begin
            p0_v    = 1'b1;
            p0_data = merged[31:0];
            p0_keep = 4'hF;
            p0_last = flush_acc && (rem_cnt == 3'd0);
            if (flush_acc && (rem_cnt != 3'd0)) begin
                p1_v    = 1'b1;
                p1_data = {8'h0, rem_data};
                p1_keep = keep_mask(rem_cnt);
                p1_last = 1'b1;
            end
        end else if (flush_acc) begin
            p0_v    = 1'b1;
            p0_data = {8'h0, rem_data};
            p0_keep = keep_mask(rem_cnt);
            p0_last = 1'b1;
        end
        push_cnt = {1'b0, p0_v} + {1'b0, p1_v};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= 24'h0;
            acc_cnt_q <= 2'd0;
        end else if (accept) begin
            if (flush_i) begin
                acc_q     <= 24'h0;
                acc_cnt_q <= 2'd0;
            end else begin
                acc_q     <= rem_data;
                acc_cnt_q <= rem_cnt[1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            occ_q    <= occ_q + OW'(push_cnt) - OW'(pop);
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (p0_v) begin
            mem_data[wr_ptr_q] <= p0_data;
            mem_keep[wr_ptr_q] <= p0_keep;
            mem_last[wr_ptr_q] <= p0_last;
        end
        if (p1_v) begin
            mem_data[wr_ptr_nxt1] <= p1_data;
            mem_keep[wr_ptr_nxt1] <= p1_keep;
            mem_last[wr_ptr_nxt1] <= p1_last;
        end
    end

endmodule

// File: tb/tb_rans_byte_packer.sv
// Directed and randomised checks of rans_byte_packer against hand-computed words
// and a byte-queue reference model.
module tb_rans_byte_packer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  valid_i = 2'b00;
    logic [15:0] enc_i = 16'h0;
    logic        flush_i = 1'b0;
    logic        ready_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_keep_o;
    logic        m_last_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    word_t cap[$];

    rans_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .enc_i     (enc_i),
        .flush_i   (flush_i),
        .ready_o   (ready_o),
        .m_data_o  (m_data_o),
        .m_keep_o  (m_keep_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Record every word the next rising edge will pop.
    always @(negedge clk_i) begin
        if (rst_ni && m_valid_o && m_ready_i)
            cap.push_back({m_data_o, m_keep_o, m_last_o});
    end

    task automatic beat(input logic [1:0] v, input logic [15:0] e, input logic f);
        valid_i = v;
        enc_i   = e;
        flush_i = f;
        @(posedge clk_i);
        #1;
        valid_i = 2'b00;
        enc_i   = 16'h0;
        flush_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        m_ready_i = 1'b0;
        #1;
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b, expected 0", m_valid_o);
        end
        checks++;
        if ({m_data_o, m_keep_o, m_last_o} !== 37'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got data=%h keep=%h last=%b, expected all 0", m_data_o, m_keep_o, m_last_o);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, expected 1", ready_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(1);
    endtask

    task automatic test_full_word;
        word_t exp;
        cap.delete();
        m_ready_i = 1'b1;
        beat(2'b11, 16'h2211, 1'b0);
        beat(2'b11, 16'h4433, 1'b0);
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'h44332211) begin
            errors++;
            $display("[TB] FAIL full_word_latency: got valid=%b data=%h, expected valid=1 data=44332211", m_valid_o, m_data_o);
        end
        idle(3);
        exp = {32'h44332211, 4'hF, 1'b0};
        checks++;
        if (cap.size() != 1) begin
            errors++;
            $display("[TB] FAIL full_word_count: got %0d words, expected 1", cap.size());
        end
        if (cap.size() > 0) begin
            checks++;
            if (cap[0] !== exp) begin
                errors++;
                $display("[TB] FAIL full_word: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         cap[0].data, cap[0].keep, cap[0].last, exp.data, exp.keep, exp.last);
            end
        end
    endtask

    task automatic test_flush_empty;
        word_t exp[2];
        cap.delete();
        m_ready_i = 1'b1;
        beat(2'b01, 16'h00AA, 1'b0);
        beat(2'b10, 16'hBB00, 1'b0);
        beat(2'b11, 16'hDDCC, 1'b0);
        beat(2'b00, 16'h0000, 1'b1);
        idle(3);
        exp[0] = {32'hDDCCBBAA, 4'hF, 1'b0};
        exp[1] = {32'h00000000, 4'h0, 1'b1};
        checks++;
        if (cap.size() != 2) begin
            errors++;
            $display("[TB] FAIL flush_empty_count: got %0d words, expected 2", cap.size());
        end
        for (int i = 0; i < 2 && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL flush_empty_word%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, cap[i].data, cap[i].keep, cap[i].last, exp[i].data, exp[i].keep, exp[i].last);
            end
        end
    endtask

    task automatic test_flush_double;
        word_t exp[2];
        cap.delete();
        m_ready_i = 1'b0;
        beat(2'b11, 16'h2211, 1'b0);
        beat(2'b01, 16'h0033, 1'b0);
        beat(2'b11, 16'h5544, 1'b1);
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'h44332211) begin
            errors++;
            $display("[TB] FAIL flush_double_head: got valid=%b data=%h, expected valid=1 data=44332211", m_valid_o, m_data_o);
        end
        m_ready_i = 1'b1;
        idle(2);
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_double_drained: got valid=%b, expected 0", m_valid_o);
        end
        exp[0] = {32'h44332211, 4'hF, 1'b0};
        exp[1] = {32'h00000055, 4'h1, 1'b1};
        checks++;
        if (cap.size() != 2) begin
            errors++;
            $display("[TB] FAIL flush_double_count: got %0d words, expected 2", cap.size());
        end
        for (int i = 0; i < 2 && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL flush_double_word%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, cap[i].data, cap[i].keep, cap[i].last, exp[i].data, exp[i].keep, exp[i].last);
            end
        end
    endtask

    task automatic test_flush_exact;
        word_t exp;
        cap.delete();
        m_ready_i = 1'b1;
        beat(2'b11, 16'h2211, 1'b0);
        beat(2'b11, 16'h4433, 1'b1);
        idle(3);
        exp = {32'h44332211, 4'hF, 1'b1};
        checks++;
        if (cap.size() != 1) begin
            errors++;
            $display("[TB] FAIL flush_exact_count: got %0d words, expected 1", cap.size());
        end
        if (cap.size() > 0) begin
            checks++;
            if (cap[0] !== exp) begin
                errors++;
                $display("[TB] FAIL flush_exact: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         cap[0].data, cap[0].keep, cap[0].last, exp.data, exp.keep, exp.last);
            end
        end
    endtask

    task automatic test_back_to_back;
        word_t exp[4];
        int    budget;
        cap.delete();
        m_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            beat(2'b11, {8'(2 * k + 1), 8'(2 * k)}, 1'b0);
            if (k == 3) begin
                checks++;
                if (ready_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL backpressure_ready_2words: got %b, expected 1", ready_o);
                end
            end
        end
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_ready_3words: got %b, expected 0", ready_o);
        end
        beat(2'b11, 16'hFFFF, 1'b0);
        beat(2'b11, 16'hFFFF, 1'b0);
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'h03020100 || m_keep_o !== 4'hF) begin
            errors++;
            $display("[TB] FAIL backpressure_head_stable: got valid=%b data=%h keep=%h, expected valid=1 data=03020100 keep=f",
                     m_valid_o, m_data_o, m_keep_o);
        end
        m_ready_i = 1'b1;
        budget = 0;
        while (m_valid_o && budget < 20) begin
            idle(1);
            budget++;
        end
        checks++;
        if (m_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL backpressure_drain: got valid=%b ready=%b, expected valid=0 ready=1", m_valid_o, ready_o);
        end
        beat(2'b00, 16'h0000, 1'b1);
        idle(3);
        exp[0] = {32'h03020100, 4'hF, 1'b0};
        exp[1] = {32'h07060504, 4'hF, 1'b0};
        exp[2] = {32'h0B0A0908, 4'hF, 1'b0};
        exp[3] = {32'h00000000, 4'h0, 1'b1};
        checks++;
        if (cap.size() != 4) begin
            errors++;
            $display("[TB] FAIL backpressure_count: got %0d words, expected 4", cap.size());
        end
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL backpressure_word%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, cap[i].data, cap[i].keep, cap[i].last, exp[i].data, exp[i].keep, exp[i].last);
            end
        end
    endtask

    task automatic test_mid_reset;
        word_t exp;
        cap.delete();
        m_ready_i = 1'b0;
        for (int k = 0; k < 5; k++)
            beat(2'b11, {8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)}, 1'b0);
        checks++;
        if (m_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_queued: got valid=%b, expected 1", m_valid_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (m_valid_o !== 1'b0 || ready_o !== 1'b1 || {m_data_o, m_keep_o, m_last_o} !== 37'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got valid=%b ready=%b data=%h keep=%h last=%b, expected valid=0 ready=1 rest 0",
                     m_valid_o, ready_o, m_data_o, m_keep_o, m_last_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cap.delete();
        m_ready_i = 1'b1;
        beat(2'b11, 16'h2211, 1'b0);
        beat(2'b11, 16'h4433, 1'b0);
        idle(3);
        exp = {32'h44332211, 4'hF, 1'b0};
        checks++;
        if (cap.size() != 1) begin
            errors++;
            $display("[TB] FAIL mid_reset_count: got %0d words, expected 1", cap.size());
        end
        if (cap.size() > 0) begin
            checks++;
            if (cap[0] !== exp) begin
                errors++;
                $display("[TB] FAIL mid_reset_word: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         cap[0].data, cap[0].keep, cap[0].last, exp.data, exp.keep, exp.last);
            end
        end
    endtask

    task automatic test_random;
        word_t       q[$];
        logic [7:0]  pend[$];
        logic [1:0]  v;
        logic [15:0] e;
        logic        f;
        logic        mr;
        logic        exp_ready;
        logic        full;
        word_t       head;
        word_t       w;
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        idle(1);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            v  = 2'($urandom_range(0, 3));
            e  = 16'($urandom);
            f  = ($urandom_range(0, 15) == 0);
            mr = ($urandom_range(0, 3) != 0);
            valid_i   = v;
            enc_i     = e;
            flush_i   = f;
            m_ready_i = mr;
            exp_ready = (q.size() <= DEPTH - 2);
            head = (q.size() > 0) ? q[0] : 37'h0;
            checks++;
            if ({ready_o, m_valid_o, m_data_o, m_keep_o, m_last_o} !== {exp_ready, (q.size() > 0), head}) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got ready=%b valid=%b data=%h keep=%h last=%b, expected ready=%b valid=%b data=%h keep=%h last=%b",
                         cyc, ready_o, m_valid_o, m_data_o, m_keep_o, m_last_o,
                         exp_ready, (q.size() > 0), head.data, head.keep, head.last);
            end
            if (mr && q.size() > 0)
                void'(q.pop_front());
            if (exp_ready) begin
                if (v[0]) pend.push_back(e[7:0]);
                if (v[1]) pend.push_back(e[15:8]);
                full = 1'b0;
                if (pend.size() >= 4) begin
                    w = 37'h0;
                    for (int i = 0; i < 4; i++)
                        w.data[8 * i +: 8] = pend.pop_front();
                    w.keep = 4'hF;
                    q.push_back(w);
                    full = 1'b1;
                end
                if (f) begin
                    if (pend.size() > 0) begin
                        w = 37'h0;
                        for (int i = 0; i < pend.size(); i++)
                            w.data[8 * i +: 8] = pend[i];
                        w.keep = 4'((5'd1 << pend.size()) - 5'd1);
                        w.last = 1'b1;
                        q.push_back(w);
                        pend.delete();
                    end else if (full) begin
                        q[q.size() - 1].last = 1'b1;
                    end else begin
                        q.push_back({32'h0, 4'h0, 1'b1});
                    end
                end
            end
            @(posedge clk_i);
            #1;
        end
        valid_i   = 2'b00;
        enc_i     = 16'h0;
        flush_i   = 1'b0;
        m_ready_i = 1'b0;
    endtask

    initial begin
        $display("[TB] starting rans_byte_packer bench");
        test_reset();
        test_full_word();
        test_flush_empty();
        test_flush_double();
        test_flush_exact();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rans_byte_packer.md
RANS_BYTE_PACKER -- requirements
Module: rans_byte_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: output word FIFO entries; power of two, >= 2.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port valid_i, input, 2 bits: byte-valid flags from the multi-stream encoder; bit0 qualifies enc_i[7:0], bit1 qualifies enc_i[15:8].
REQ-005 SHALL have port enc_i, input, 16 bits: encoded renormalisation bytes from the multi-stream encoder.
REQ-006 SHALL have port flush_i, input, 1 bit: end-of-block request; terminate the current output packet.
REQ-007 SHALL have port ready_o, output, 1 bit: upstream may advance; drives the encoder's ready_i.
REQ-008 SHALL have port m_data_o, output, 32 bits: packed output word.
REQ-009 SHALL have port m_keep_o, output, 4 bits: byte-enable per m_data_o byte lane.
REQ-010 SHALL have port m_last_o, output, 1 bit: final word of a packet.
REQ-011 SHALL have port m_valid_o, output, 1 bit: output word available.
REQ-012 SHALL have port m_ready_i, input, 1 bit: downstream accepts the word.

Function
REQ-013 SHALL accept an input beat (valid_i, enc_i, flush_i) in any cycle where ready_o=1; inputs SHALL be ignored when ready_o=0.
REQ-014 SHALL drive ready_o=1 iff the FIFO has >= 2 free entries, combinationally from registered occupancy.
REQ-015 SHALL append accepted bytes in order enc_i[7:0] first, then enc_i[15:8], skipping bytes whose valid bit is 0; valid_i=2'b10 appends only enc_i[15:8].
REQ-016 SHALL hold 0..3 pending bytes in an accumulator with a 2-bit count; byte n of a word occupies m_data_o[8n+7:8n] (little-endian lane order).
REQ-017 SHALL, when pending+new bytes >= 4, push the first 4 bytes as one word (keep=4'hF, last=0) in the same cycle, and keep the 0..1 remainder as the new pending bytes.
REQ-018 SHALL, on accepted flush_i, first merge that beat's bytes, then push the 0..3 remaining bytes as one word with keep = low-contiguous mask of that count and last=1, and clear the accumulator; at most 2 pushes per cycle.
REQ-019 SHALL, on flush with zero remaining bytes after merge, push keep=4'h0, last=1 only if no full word was pushed that cycle; otherwise set last=1 on the full word pushed that cycle.
REQ-020 SHALL present the FIFO head on m_data_o/m_keep_o/m_last_o with m_valid_o = FIFO non-empty; m_data_o, m_keep_o and m_last_o SHALL be 0 while m_valid_o=0.
REQ-021 SHALL pop the head on m_valid_o && m_ready_i; push and pop in the same cycle SHALL be supported, with occupancy updated by pushes minus pop.
REQ-022 SHALL keep head outputs stable while m_valid_o=1 and m_ready_i=0.
REQ-023 SHALL never overflow, underflow or drop a byte; occupancy SHALL be width clog2(FIFO_DEPTH)+1, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 SHALL impose a latency of one cycle from the accepting edge of the beat that completes a word to m_valid_o for that word when the FIFO was empty.

Reset
REQ-025 SHALL, while rst_ni=0, clear the accumulator count, FIFO pointers and occupancy, with m_valid_o=0, m_data_o=0, m_keep_o=0, m_last_o=0; ready_o SHALL then read 1.
REQ-026 SHALL discard pending bytes and queued words on reset asserted mid-packet; the first post-reset byte SHALL land in lane 0.

Verification
REQ-027 SHALL pass this case: beats (2'b11,16'h2211), (2'b11,16'h4433), m_ready_i=1 -> one word m_data_o=32'h44332211, keep=4'hF, last=0.
REQ-028 SHALL pass this case: beats (2'b01,8'hAA), (2'b10,16'hBB00), (2'b11,16'hDDCC) then flush_i with valid_i=0 -> word 32'hDDCCBBAA keep F last 0; then keep=4'h0 last=1.
REQ-029 SHALL pass this case: 3 pending bytes 11,22,33 plus beat (2'b11,16'h5544) with flush_i=1 -> 32'h44332211 keep F last 0, then 32'h00000055 keep 4'h1 last 1, both pushed in the same cycle.
REQ-030 SHALL pass this case: m_ready_i=0 with continuous 2-byte beats -> ready_o falls when occupancy reaches FIFO_DEPTH-1 (3 words with default); no word lost; after m_ready_i=1, all words drain in order.
REQ-031 SHALL pass this case: random valid_i/flush_i/m_ready_i for 10k cycles against a byte-queue reference model -> identical byte stream, keep and last, and no push while full.
REQ-032 SHALL pass this case: rst_ni pulsed low with 2 pending bytes and 2 queued words -> m_valid_o=0 immediately and ready_o=1; the next 4 bytes form a fresh word starting at lane 0.
